spu_mamulred_seq: RTL and testbench

- Montgomery multiply-reduce sequencer that sits directly downstream of the modular-exponentiation controller.
- Consumes the controller's start pulses (A==B square, A!=B multiply) and steps the multiplier datapath through a word-serial multiply pass, then a reduction pass.
- Returns the one-cycle red_done pulse that advances the exponentiation state machine.
- Owns the operand word index and the pipeline-drain timing for both passes.

---
 rtl/spu_mamulred_seq.sv | 135 +++++++++++++
 tb/tb_spu_mamulred_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spu_mamulred_seq.sv
// Montgomery multiply-reduce sequencer: steps the multiplier through a word-serial
// multiply pass and a reduction pass, each followed by a pipeline drain.
module spu_mamulred_seq #(
    parameter int LEN_W   = 6,
    parameter int MUL_LAT = 3
) (
    input  logic             rclk,
    input  logic             reset,
    input  logic             se,
    input  logic             spu_maexp_start_mulred_aequb,
    input  logic             spu_maexp_start_mulred_anoteqb,
    input  logic [LEN_W-1:0] spu_mactl_len,
    input  logic             spu_mactl_kill_op,
    input  logic             spu_mamem_stall,
    output logic             spu_mamul_mul_vld,
    output logic             spu_mamul_red_vld,
    output logic [LEN_W-1:0] spu_mamul_oprnd_idx,
    output logic             spu_mamul_sqr_sel,
    output logic             spu_mared_red_done,
    output logic             spu_mamul_busy,
    output logic             spu_mamul_start_err
);

    typedef enum logic [5:0] {
        IDLE = 6'b000001,
        MUL  = 6'b000010,
        MDRN = 6'b000100,
        RED  = 6'b001000,
        RDRN = 6'b010000,
        DONE = 6'b100000
    } state_t;

    localparam logic [2:0] DRN_LAST = 3'(MUL_LAT - 1);

    state_t           r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_idx;
    logic [2:0]       r_drn;
    logic             r_sqr_sel;
    logic             r_start_err;

    logic w_any_start;
    logic w_idle;
    logic w_unused_se;

    assign w_any_start = spu_maexp_start_mulred_aequb | spu_maexp_start_mulred_anoteqb;
    assign w_idle      = (r_state == IDLE);
    assign w_unused_se = se;

    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_idx       <= '0;
            r_drn       <= '0;
            r_sqr_sel   <= 1'b0;
            r_start_err <= 1'b0;
        end else begin
            // A simultaneous pair of starts, or any start while busy, is flagged.
            r_start_err <= (spu_maexp_start_mulred_aequb & spu_maexp_start_mulred_anoteqb)
                         | (w_any_start & ~w_idle);
            if (!w_idle && spu_mactl_kill_op) begin
                r_state <= IDLE;
                r_idx   <= '0;
                r_drn   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_any_start && !spu_mactl_kill_op) begin
                            r_state   <= MUL;
                            r_len     <= spu_mactl_len;
                            r_sqr_sel <= spu_maexp_start_mulred_aequb;
                            r_idx     <= '0;
                            r_drn     <= '0;
                        end
                    end
                    MUL: begin
                        if (!spu_mamem_stall) begin
                            if (r_idx == r_len) begin
                                r_idx   <= '0;
                                r_state <= MDRN;
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end
                    end
                    MDRN: begin
                        if (r_drn == DRN_LAST) begin
                            r_drn   <= '0;
                            r_state <= RED;
                        end else begin
                            r_drn <= r_drn + 3'd1;
                        end
                    end
                    RED: begin
                        if (!spu_mamem_stall) begin
                            if (r_idx == r_len) begin
                                r_idx   <= '0;
                                r_state <= RDRN;
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end
                    end
                    RDRN: begin
                        if (r_drn == DRN_LAST) begin
                            r_drn   <= '0;
                            r_state <= DONE;
                        end else begin
                            r_drn <= r_drn + 3'd1;
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_idx   <= '0;
                        r_drn   <= '0;
                    end
                endcase
            end
        end
    end

    // Issue valids follow the stall input directly so a busy memory port costs no extra cycle.
    assign spu_mamul_mul_vld   = (r_state == MUL) & ~spu_mamem_stall;
    assign spu_mamul_red_vld   = (r_state == RED) & ~spu_mamem_stall;
    assign spu_mamul_oprnd_idx = r_idx;
    assign spu_mamul_sqr_sel   = r_sqr_sel;
    assign spu_mared_red_done  = (r_state == DONE);
    assign spu_mamul_busy      = ~w_idle;
    assign spu_mamul_start_err = r_start_err;

endmodule

// File: tb/tb_spu_mamulred_seq.sv
// Self-checking bench for spu_mamulred_seq: table of operations with a scoreboard of
// expected issue/done events, plus hand sequences for kill and asynchronous reset.
module tb_spu_mamulred_seq;

    localparam int LEN_W   = 6;
    localparam int MUL_LAT = 3;

    logic             rclk;
    logic             reset;
    logic             se;
    logic             spu_maexp_start_mulred_aequb;
    logic             spu_maexp_start_mulred_anoteqb;
    logic [LEN_W-1:0] spu_mactl_len;
    logic             spu_mactl_kill_op;
    logic             spu_mamem_stall;
    logic             spu_mamul_mul_vld;
    logic             spu_mamul_red_vld;
    logic [LEN_W-1:0] spu_mamul_oprnd_idx;
    logic             spu_mamul_sqr_sel;
    logic             spu_mared_red_done;
    logic             spu_mamul_busy;
    logic             spu_mamul_start_err;

    spu_mamulred_seq #(.LEN_W(LEN_W), .MUL_LAT(MUL_LAT)) dut (
        .rclk                           (rclk),
        .reset                          (reset),
        .se                             (se),
        .spu_maexp_start_mulred_aequb   (spu_maexp_start_mulred_aequb),
        .spu_maexp_start_mulred_anoteqb (spu_maexp_start_mulred_anoteqb),
        .spu_mactl_len                  (spu_mactl_len),
        .spu_mactl_kill_op              (spu_mactl_kill_op),
        .spu_mamem_stall                (spu_mamem_stall),
        .spu_mamul_mul_vld              (spu_mamul_mul_vld),
        .spu_mamul_red_vld              (spu_mamul_red_vld),
        .spu_mamul_oprnd_idx            (spu_mamul_oprnd_idx),
        .spu_mamul_sqr_sel              (spu_mamul_sqr_sel),
        .spu_mared_red_done             (spu_mared_red_done),
        .spu_mamul_busy                 (spu_mamul_busy),
        .spu_mamul_start_err            (spu_mamul_start_err)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // kind: 1 = multiply issue, 2 = reduction issue, 3 = red_done
    typedef struct {
        int cyc;
        int kind;
        int idx;
    } ev_t;

    typedef struct {
        bit sqr;
        bit both;
        int len;
        int stallAt;
        int stallN;
        int extraAt;
        int killAt;
        int expDone;
        bit expSqr;
    } vec_t;

    ev_t  sb[$];
    vec_t vecs[8];
    int   total = 0;
    int   bad   = 0;

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pushEv(input int cyc, input int kind, input int idx, input int killAt);
        ev_t e;
        if (killAt == 0 || cyc <= killAt) begin
            e.cyc  = cyc;
            e.kind = kind;
            e.idx  = idx;
            sb.push_back(e);
        end
    endtask

    task automatic scoreCycle(input int c);
        int  kind;
        ev_t e;
        if (spu_mamul_mul_vld && spu_mamul_red_vld)
            checkOutput("both_vld", 1, 0);
        if (spu_mamul_mul_vld || spu_mamul_red_vld || spu_mared_red_done) begin
            kind = spu_mamul_mul_vld ? 1 : (spu_mamul_red_vld ? 2 : 3);
            if (sb.size() == 0) begin
                checkOutput("sb_unexpected_kind", kind, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("sb_cyc", c, e.cyc);
                checkOutput("sb_kind", kind, e.kind);
                if (kind != 3)
                    checkOutput("sb_idx", int'(spu_mamul_oprnd_idx), e.idx);
            end
        end
    endtask

    // Drive one operation starting this cycle and score it cycle by cycle.
    task automatic applyStimulus(input vec_t v);
        int c;
        int i;
        int maxC;
        bit expErr;
        bit stalled;
        @(posedge rclk);
        #1;
        spu_maexp_start_mulred_aequb   = v.sqr | v.both;
        spu_maexp_start_mulred_anoteqb = ~v.sqr | v.both;
        spu_mactl_len                  = LEN_W'(v.len);
        c = 1;
        i = 0;
        while (i <= v.len) begin
            if (v.stallAt > 0 && c >= v.stallAt && c < v.stallAt + v.stallN) begin
                c++;
            end else begin
                pushEv(c, 1, i, v.killAt);
                i++;
                c++;
            end
        end
        c += MUL_LAT;
        for (int j = 0; j <= v.len; j++) begin
            pushEv(c, 2, j, v.killAt);
            c++;
        end
        if (v.killAt == 0)
            pushEv(v.expDone, 3, 0, 0);
        maxC = (v.killAt == 0) ? v.expDone + 3 : v.killAt + 4;
        for (int k = 1; k <= maxC; k++) begin
            @(posedge rclk);
            #1;
            stalled = (v.stallAt > 0 && k >= v.stallAt && k < v.stallAt + v.stallN);
            spu_mamem_stall                = stalled;
            spu_maexp_start_mulred_aequb   = (v.extraAt > 0 && k == v.extraAt);
            spu_maexp_start_mulred_anoteqb = 1'b0;
            spu_mactl_kill_op              = (v.killAt > 0 && k == v.killAt);
            @(negedge rclk);
            scoreCycle(k);
            expErr = (v.both && k == 1) || (v.extraAt > 0 && k == v.extraAt + 1);
            checkOutput("start_err", int'(spu_mamul_start_err), int'(expErr));
            if (stalled) begin
                checkOutput("stall_mul_vld", int'(spu_mamul_mul_vld), 0);
                checkOutput("stall_idx", int'(spu_mamul_oprnd_idx), v.stallAt - 1);
            end
            if (v.killAt > 0 && k == v.killAt + 1)
                checkOutput("kill_busy", int'(spu_mamul_busy), 0);
        end
        spu_mamem_stall   = 1'b0;
        spu_mactl_kill_op = 1'b0;
        checkOutput("sb_empty", sb.size(), 0);
        checkOutput("sqr_sel", int'(spu_mamul_sqr_sel), int'(v.expSqr));
        checkOutput("busy_end", int'(spu_mamul_busy), 0);
        sb.delete();
    endtask

    function automatic int allOutputs();
        return int'({spu_mamul_mul_vld, spu_mamul_red_vld, spu_mamul_oprnd_idx,
                     spu_mamul_sqr_sel, spu_mared_red_done, spu_mamul_busy,
                     spu_mamul_start_err});
    endfunction

    initial begin
        //          sqr both len stAt stN extra kill done sqrSel
        vecs[0] = '{1'b0, 1'b0,  3, 0, 0, 0, 0,  15, 1'b0};
        vecs[1] = '{1'b1, 1'b0,  0, 0, 0, 0, 0,   9, 1'b1};
        vecs[2] = '{1'b0, 1'b0,  3, 2, 2, 0, 0,  17, 1'b0};
        vecs[3] = '{1'b1, 1'b1,  0, 0, 0, 0, 0,   9, 1'b1};
        vecs[4] = '{1'b0, 1'b0,  3, 0, 0, 9, 0,  15, 1'b0};
        vecs[5] = '{1'b0, 1'b0,  3, 0, 0, 0, 6,  -1, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 63, 0, 0, 0, 0, 135, 1'b1};
        vecs[7] = '{1'b0, 1'b0,  5, 3, 1, 0, 0,  20, 1'b0};

        reset                          = 1'b1;
        se                             = 1'b0;
        spu_maexp_start_mulred_aequb   = 1'b0;
        spu_maexp_start_mulred_anoteqb = 1'b0;
        spu_mactl_len                  = '0;
        spu_mactl_kill_op              = 1'b0;
        spu_mamem_stall                = 1'b0;
        repeat (2) @(posedge rclk);
        #1;
        checkOutput("reset_outputs", allOutputs(), 0);
        reset = 1'b0;

        for (int n = 0; n < 8; n++)
            applyStimulus(vecs[n]);

        // Kill together with a start in IDLE drops the start.
        @(posedge rclk);
        #1;
        spu_maexp_start_mulred_anoteqb = 1'b1;
        spu_mactl_kill_op              = 1'b1;
        spu_mactl_len                  = 6'd2;
        @(posedge rclk);
        #1;
        spu_maexp_start_mulred_anoteqb = 1'b0;
        spu_mactl_kill_op              = 1'b0;
        @(negedge rclk);
        checkOutput("kill_start_busy", int'(spu_mamul_busy), 0);
        checkOutput("kill_start_mul_vld", int'(spu_mamul_mul_vld), 0);

        // Asynchronous reset in the middle of the reduction pass.
        @(posedge rclk);
        #1;
        spu_maexp_start_mulred_aequb = 1'b1;
        spu_mactl_len                = 6'd3;
        @(posedge rclk);
        #1;
        spu_maexp_start_mulred_aequb = 1'b0;
        repeat (8) @(posedge rclk);
        #1;
        checkOutput("pre_reset_red_vld", int'(spu_mamul_red_vld), 1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_outputs", allOutputs(), 0);
        #2;
        reset = 1'b0;
        @(negedge rclk);
        checkOutput("post_reset_busy", int'(spu_mamul_busy), 0);
        applyStimulus(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
